// File: rtl/dispatch_stall_ctrl_pkg.sv
// Shared types for the dispatch stall controller: RS class encoding, FSM encoding and a
// saturating-increment helper used by the optional performance counters.
package ctrl_types;

  localparam int NUM_FU = 3;
  localparam int FU_W   = $clog2(NUM_FU);

  typedef enum logic [FU_W-1:0] {
    FU_ALU    = 2'd0,
    FU_MULDIV = 2'd1,
    FU_MEM    = 2'd2
  } fu_class_t;

  typedef logic [0:0] dispatch_state_t;
  localparam dispatch_state_t ST_RUN     = 1'b0;
  localparam dispatch_state_t ST_RECOVER = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dispatch_stall_ctrl_rs_credit.sv
// Per-class reservation-station credit counter, plus the checker that guards against
// credits being returned to an RS that is already empty.
module rs_credit_counter #(
  parameter int RS_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc,
  input  logic                            issue,
  input  logic                            reload,
  output logic [$clog2(RS_DEPTH+1)-1:0]   count,
  output logic                            zero
);

  localparam int CW = $clog2(RS_DEPTH + 1);

  // A flush empties the RS, so reload wins over any alloc/issue that cycle.
  always_ff @(posedge clk) begin
    if (rst || reload) begin
      count <= CW'(RS_DEPTH);
    end else begin
      count <= count + CW'(issue) - CW'(alloc);
    end
  end

  assign zero = (count == '0);

  rs_credit_chk #(.RS_DEPTH(RS_DEPTH)) u_chk (
    .clk   (clk),
    .rst   (rst),
    .alloc (alloc),
    .issue (issue),
    .count (count)
  );

endmodule

module rs_credit_chk #(
  parameter int RS_DEPTH = 8
) (
  input logic                          clk,
  input logic                          rst,
  input logic                          alloc,
  input logic                          issue,
  input logic [$clog2(RS_DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(RS_DEPTH + 1);

  a_no_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && !alloc && (count == CW'(RS_DEPTH))));

endmodule

// File: rtl/dispatch_stall_ctrl.sv
// Dispatch stall controller: gates IQ pop and holding-register freeze on ROB, PRF and RS credits,
// and sequences post-flush recovery. Optional stall counters: DISPATCH_STALL_PERF_EN.
module dispatch_stall_ctrl
  import ctrl_types::*;
#(
  parameter int NUM_FU     = ctrl_types::NUM_FU,
  parameter int RS_DEPTH   = 8,
  parameter int FLUSH_WAIT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      iq_empty,
  input  logic                      hold_valid,
  input  logic [$clog2(NUM_FU)-1:0] hold_fu,
  input  logic                      hold_has_rd,
  input  logic                      rob_full,
  input  logic                      freelist_empty,
  input  logic [NUM_FU-1:0]         rs_issue,
  output logic                      iq_re,
  output logic                      dis_freeze,
  output logic                      dispatch_fire,
  output logic [NUM_FU-1:0]         rs_alloc,
  output logic                      recover_busy
`ifdef DISPATCH_STALL_PERF_EN
  ,
  output logic [31:0]               perf_stall_rob,
  output logic [31:0]               perf_stall_prf,
  output logic [31:0]               perf_stall_rs
`endif
);

  localparam int FUW = $clog2(NUM_FU);
  localparam int CW  = $clog2(RS_DEPTH + 1);
  localparam int RW  = (FLUSH_WAIT < 1) ? 1 : $clog2(FLUSH_WAIT + 1);

  dispatch_state_t   state_r;
  logic [RW-1:0]     rcnt_r;
  logic [NUM_FU-1:0] hot_s;
  logic [NUM_FU-1:0] zero_s;
  logic [NUM_FU-1:0] issue_s;
  logic [CW-1:0]     credit_s [NUM_FU];
  logic              run_s;
  logic              rob_blk_s;
  logic              prf_blk_s;
  logic              rs_blk_s;
  logic              block_s;

  // Stall decision; a class that decodes to no RS is treated as out of credit.
  always_comb begin
    hot_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      hot_s[i] = (hold_fu == FUW'(i));
    end
    run_s         = (state_r == ST_RUN) && !flush;
    rob_blk_s     = hold_valid && rob_full;
    prf_blk_s     = hold_valid && hold_has_rd && freelist_empty;
    rs_blk_s      = hold_valid && ((hot_s == '0) || ((hot_s & zero_s) != '0));
    block_s       = rob_blk_s || prf_blk_s || rs_blk_s;
    iq_re         = run_s && !iq_empty && !block_s;
    dis_freeze    = run_s && block_s;
    dispatch_fire = run_s && hold_valid && !block_s;
    rs_alloc      = dispatch_fire ? hot_s : '0;
    issue_s       = run_s ? rs_issue : '0;
    recover_busy  = (state_r == ST_RECOVER);
  end

  // Recovery sequencing; a flush in any state restarts the wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      rcnt_r  <= '0;
    end else if (flush) begin
      if (FLUSH_WAIT == 0) begin
        state_r <= ST_RUN;
        rcnt_r  <= '0;
      end else begin
        state_r <= ST_RECOVER;
        rcnt_r  <= RW'(FLUSH_WAIT);
      end
    end else begin
      case (state_r)
        ST_RECOVER: begin
          if (rcnt_r <= RW'(1)) begin
            state_r <= ST_RUN;
            rcnt_r  <= '0;
          end else begin
            rcnt_r <= rcnt_r - RW'(1);
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
          rcnt_r  <= '0;
        end
        default: begin
          state_r <= ST_RUN;
          rcnt_r  <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_rs
    rs_credit_counter #(.RS_DEPTH(RS_DEPTH)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .alloc  (rs_alloc[g]),
      .issue  (issue_s[g]),
      .reload (flush),
      .count  (credit_s[g]),
      .zero   (zero_s[g])
    );
  end

`ifdef DISPATCH_STALL_PERF_EN
  // Each frozen RUN cycle is charged to the first cause only: ROB, then PRF, then RS.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_rob <= 32'd0;
      perf_stall_prf <= 32'd0;
      perf_stall_rs  <= 32'd0;
    end else if (dis_freeze) begin
      if (rob_blk_s) begin
        perf_stall_rob <= sat_inc32(perf_stall_rob);
      end else if (prf_blk_s) begin
        perf_stall_prf <= sat_inc32(perf_stall_prf);
      end else begin
        perf_stall_rs <= sat_inc32(perf_stall_rs);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dispatch_stall_ctrl.sv
// Self-checking bench for dispatch_stall_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a credit/recovery reference model.
module tb_dispatch_stall_ctrl;
  import ctrl_types::*;

  localparam int DEPTH = 8;
  localparam int WAIT  = 2;

  logic       clk = 1'b0;
  logic       rst, flush, iq_empty, hold_valid, hold_has_rd, rob_full, freelist_empty;
  logic [1:0] hold_fu;
  logic [2:0] rs_issue, rs_alloc;
  logic       iq_re, dis_freeze, dispatch_fire, recover_busy;
`ifdef DISPATCH_STALL_PERF_EN
  logic [31:0] perf_stall_rob, perf_stall_prf, perf_stall_rs;
  int          perf_m [3];
`endif

  always #5 clk = ~clk;

  dispatch_stall_ctrl #(.NUM_FU(3), .RS_DEPTH(DEPTH), .FLUSH_WAIT(WAIT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .iq_empty(iq_empty), .hold_valid(hold_valid),
    .hold_fu(hold_fu), .hold_has_rd(hold_has_rd), .rob_full(rob_full),
    .freelist_empty(freelist_empty), .rs_issue(rs_issue), .iq_re(iq_re),
    .dis_freeze(dis_freeze), .dispatch_fire(dispatch_fire), .rs_alloc(rs_alloc),
    .recover_busy(recover_busy)
`ifdef DISPATCH_STALL_PERF_EN
    , .perf_stall_rob(perf_stall_rob), .perf_stall_prf(perf_stall_prf),
    .perf_stall_rs(perf_stall_rs)
`endif
  );

  int checks = 0;
  int failures = 0;
  int cred [3];
  int rec_left;
  logic [6:0] act_o;

  typedef struct {
    logic f, e, hv;
    logic [1:0] fu;
    logic rd, rob, fle;
    logic [2:0] iss;
    logic [6:0] exp;  // {iq_re, dis_freeze, dispatch_fire, rs_alloc[2:0], recover_busy}
  } vec_t;
  vec_t tbl [20];

  function automatic vec_t mk(input logic f, input logic e, input logic hv, input logic [1:0] fu,
                              input logic rd, input logic rob, input logic fle,
                              input logic [2:0] iss, input logic [6:0] exp);
    vec_t v;
    v.f = f; v.e = e; v.hv = hv; v.fu = fu; v.rd = rd; v.rob = rob; v.fle = fle;
    v.iss = iss; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: drive, compare combinational outputs with the model, clock, advance the model.
  task automatic apply(input logic r, input logic f, input logic e, input logic hv,
                       input logic [1:0] fu, input logic rd, input logic rob, input logic fle,
                       input logic [2:0] iss);
    logic run, blocked, fire;
    logic [2:0] alloc;
    rst = r; flush = f; iq_empty = e; hold_valid = hv; hold_fu = fu;
    hold_has_rd = rd; rob_full = rob; freelist_empty = fle; rs_issue = iss;
    #2;
    run     = (rec_left == 0) && !f;
    blocked = hv && (rob || (rd && fle) || (cred[fu] == 0));
    fire    = run && hv && !blocked;
    alloc   = fire ? (3'b001 << fu) : 3'b000;
    act_o   = {iq_re, dis_freeze, dispatch_fire, rs_alloc, recover_busy};
    check("outputs", 32'(act_o),
          32'({run && !e && !blocked, run && blocked, fire, alloc, rec_left > 0}));
`ifdef DISPATCH_STALL_PERF_EN
    if (run && blocked) begin
      if (rob) perf_m[0]++;
      else if (rd && fle) perf_m[1]++;
      else perf_m[2]++;
    end
`endif
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 3; i++) cred[i] = DEPTH;
      rec_left = 0;
`ifdef DISPATCH_STALL_PERF_EN
      for (int i = 0; i < 3; i++) perf_m[i] = 0;
`endif
    end else if (f) begin
      for (int i = 0; i < 3; i++) cred[i] = DEPTH;
      rec_left = WAIT;
    end else if (rec_left > 0) begin
      rec_left--;
    end else begin
      for (int i = 0; i < 3; i++) cred[i] = cred[i] + int'(iss[i]) - int'(alloc[i]);
    end
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("credit%0d", i), 32'(dut.credit_s[i]), 32'(cred[i]));
`ifdef DISPATCH_STALL_PERF_EN
    check("perf_rob", perf_stall_rob, 32'(perf_m[0]));
    check("perf_prf", perf_stall_prf, 32'(perf_m[1]));
    check("perf_rs",  perf_stall_rs,  32'(perf_m[2]));
`endif
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic fire_n(input logic [1:0] fu, input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 1'b1, fu, 1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; iq_empty = 1'b1; hold_valid = 1'b0; hold_fu = 2'd0;
    hold_has_rd = 1'b0; rob_full = 1'b0; freelist_empty = 1'b0; rs_issue = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cred[i] = DEPTH;
    rec_left = 0;
`ifdef DISPATCH_STALL_PERF_EN
    for (int i = 0; i < 3; i++) perf_m[i] = 0;
`endif
    for (int i = 0; i < 3; i++) check($sformatf("reset_credit%0d", i), 32'(dut.credit_s[i]), 32'd8);

    tbl[0] = mk(1'b0, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000, 7'b100_000_0);
    for (int i = 1; i <= 8; i++)
      tbl[i] = mk(1'b0, 1'b0, 1'b1, FU_ALU, 1'b1, 1'b0, 1'b0, 3'b000, 7'b101_001_0);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, FU_ALU,    1'b1, 1'b0, 1'b0, 3'b000, 7'b010_000_0);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, FU_MEM,    1'b1, 1'b0, 1'b0, 3'b000, 7'b101_100_0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, FU_ALU,    1'b1, 1'b0, 1'b0, 3'b001, 7'b010_000_0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, FU_ALU,    1'b1, 1'b0, 1'b0, 3'b000, 7'b101_001_0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, FU_MULDIV, 1'b1, 1'b0, 1'b1, 3'b000, 7'b010_000_0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, FU_MULDIV, 1'b0, 1'b0, 1'b1, 3'b000, 7'b101_010_0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, FU_MEM,    1'b0, 1'b1, 1'b0, 3'b000, 7'b010_000_0);
    tbl[16] = mk(1'b1, 1'b0, 1'b1, FU_MEM,    1'b0, 1'b0, 1'b0, 3'b000, 7'b000_000_0);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, FU_ALU,    1'b0, 1'b0, 1'b0, 3'b000, 7'b000_000_1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, FU_ALU,    1'b0, 1'b0, 1'b0, 3'b000, 7'b000_000_1);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, FU_ALU,    1'b0, 1'b0, 1'b0, 3'b000, 7'b100_000_0);
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, tbl[i].f, tbl[i].e, tbl[i].hv, tbl[i].fu, tbl[i].rd, tbl[i].rob,
            tbl[i].fle, tbl[i].iss);
      check($sformatf("vec%0d", i), 32'(act_o), 32'(tbl[i].exp));
    end

    // Flush with credits {3,5,0}: two recovery cycles, then RUN with full credits.
    fire_n(FU_ALU, 5);
    fire_n(FU_MULDIV, 3);
    fire_n(FU_MEM, 8);
    check("pre_flush_alu", 32'(dut.credit_s[0]), 32'd3);
    check("pre_flush_mul", 32'(dut.credit_s[1]), 32'd5);
    check("pre_flush_mem", 32'(dut.credit_s[2]), 32'd0);
    apply(1'b0, 1'b1, 1'b0, 1'b1, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b011);
    idle(); check("rec1", 32'(act_o), 32'(7'b000_000_1));
    idle(); check("rec2", 32'(act_o), 32'(7'b000_000_1));
    idle(); check("rec_done", 32'(act_o), 32'(7'b100_000_0));
    for (int i = 0; i < 3; i++) check($sformatf("post_flush%0d", i), 32'(dut.credit_s[i]), 32'd8);

    // Flush during recovery cycle 1 reloads the wait.
    apply(1'b0, 1'b1, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000);
    apply(1'b0, 1'b1, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(); check("reload1", 32'(act_o), 32'(7'b000_000_1));
    idle(); check("reload2", 32'(act_o), 32'(7'b000_000_1));
    idle(); check("reload_done", 32'(act_o), 32'(7'b100_000_0));

    // Reset mid-recovery returns straight to RUN.
    apply(1'b0, 1'b1, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000);
    apply(1'b1, 1'b0, 1'b0, 1'b0, FU_ALU, 1'b0, 1'b0, 1'b0, 3'b000);
    idle(); check("rst_mid_rec", 32'(act_o), 32'(7'b100_000_0));

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] iss;
      for (int i = 0; i < 3; i++) iss[i] = (cred[i] < DEPTH) && ($urandom_range(0, 2) == 0);
      apply($urandom_range(0, 250) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, 2'($urandom_range(0, 2)), 1'($urandom),
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, iss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
